local_mem_burst_arbiter: RTL

// - Shares one local-memory Avalon-MM bank between two DMA masters (m0, m1), e.g. DMA read and write engines.
// - Round-robin, burst-aware: write bursts hold the grant until the last beat; read bursts release the grant after the command.
// - Read responses are routed back to the issuing master through an in-order tag FIFO. Sits between the DMA masters and local_mem[n].

---
 rtl/lmarb_pkg.sv | 22 ++
 rtl/lmarb_tag_fifo.sv | 65 ++++++
 rtl/local_mem_burst_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lmarb_pkg.sv
// Shared types and constants for the local-memory burst arbiter.
package lmarb_pkg;

    localparam int unsigned BURST_WIDTH = 7;

    // One outstanding read burst: issuing master and beats still to return.
    typedef struct packed {
        logic                   id;
        logic [BURST_WIDTH-1:0] beats;
    } tag_t;

    typedef enum logic {
        ARB      = 1'b0,
        WR_BURST = 1'b1
    } arb_state_e;

    // A burstcount of zero is counted as a single beat.
    function automatic logic [BURST_WIDTH-1:0] eff_beats(input logic [BURST_WIDTH-1:0] bc);
        return (bc == '0) ? BURST_WIDTH'(1) : bc;
    endfunction

endpackage

// File: rtl/lmarb_tag_fifo.sv
// In-order tag FIFO for outstanding read bursts; the head beat count is decremented in place.
module lmarb_tag_fifo
    import lmarb_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  tag_t                       i_push_data,
    input  logic                       i_pop,
    input  logic                       i_dec,
    output tag_t                       o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    tag_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;
    logic w_dec;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;
    assign w_dec  = i_dec  & ~o_empty & ~i_pop;

    // Pointer, occupancy and storage update; push and pop in one cycle leave occupancy unchanged.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_dec) begin
                r_mem[r_rd_ptr].beats <= r_mem[r_rd_ptr].beats - BURST_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/local_mem_burst_arbiter.sv
// Round-robin, burst-aware arbiter sharing one local-memory Avalon-MM bank between two DMA masters.
module local_mem_burst_arbiter
    import lmarb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned TAG_DEPTH  = 16
) (
    input  logic                          host_clk_clk,
    input  logic                          reset_reset_n,

    input  logic                          m0_read,
    input  logic                          m0_write,
    input  logic [ADDR_WIDTH-1:0]         m0_address,
    input  logic [BURST_WIDTH-1:0]        m0_burstcount,
    input  logic [DATA_WIDTH-1:0]         m0_writedata,
    input  logic [DATA_WIDTH/8-1:0]       m0_byteenable,
    output logic                          m0_waitrequest,
    output logic [DATA_WIDTH-1:0]         m0_readdata,
    output logic                          m0_readdatavalid,

    input  logic                          m1_read,
    input  logic                          m1_write,
    input  logic [ADDR_WIDTH-1:0]         m1_address,
    input  logic [BURST_WIDTH-1:0]        m1_burstcount,
    input  logic [DATA_WIDTH-1:0]         m1_writedata,
    input  logic [DATA_WIDTH/8-1:0]       m1_byteenable,
    output logic                          m1_waitrequest,
    output logic [DATA_WIDTH-1:0]         m1_readdata,
    output logic                          m1_readdatavalid,

    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [BURST_WIDTH-1:0]        mem_burstcount,
    output logic [DATA_WIDTH-1:0]         mem_writedata,
    output logic [DATA_WIDTH/8-1:0]       mem_byteenable,
    input  logic                          mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]         mem_readdata,
    input  logic                          mem_readdatavalid,

    output logic [$clog2(TAG_DEPTH):0]    rd_outstanding,
    output logic                          err_burst,
    output logic                          err_rsp
);

    localparam int unsigned CW = $clog2(TAG_DEPTH) + 1;

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic                   r_rr_ptr;
    logic                   r_lock_id;
    logic [BURST_WIDTH-1:0] r_beats_left;
    logic                   r_err_burst;
    logic                   r_err_rsp;

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CW-1:0]          w_fifo_count;
    tag_t                   w_head;
    tag_t                   w_push_tag;

    logic                   w_req0;
    logic                   w_req1;
    logic                   w_gnt_vld;
    logic                   w_gnt_id;
    logic                   w_sel_read;
    logic                   w_sel_write;
    logic [BURST_WIDTH-1:0] w_sel_bc;
    logic [BURST_WIDTH-1:0] w_bc_eff;
    logic                   w_bc_bad;
    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic                   w_rsp_hit;
    logic                   w_pop;
    logic                   w_dec;

    // A master requests when writing, or reading while a tag slot is free.
    assign w_req0 = m0_write | (m0_read & ~w_fifo_full);
    assign w_req1 = m1_write | (m1_read & ~w_fifo_full);

    // Command payload follows the granted master; strobes are qualified separately.
    assign w_sel_read     = w_gnt_id ? m1_read       : m0_read;
    assign w_sel_write    = w_gnt_id ? m1_write      : m0_write;
    assign w_sel_bc       = w_gnt_id ? m1_burstcount : m0_burstcount;
    assign mem_address    = w_gnt_id ? m1_address    : m0_address;
    assign mem_burstcount = w_sel_bc;
    assign mem_writedata  = w_gnt_id ? m1_writedata  : m0_writedata;
    assign mem_byteenable = w_gnt_id ? m1_byteenable : m0_byteenable;

    assign w_bc_eff = eff_beats(w_sel_bc);
    assign w_bc_bad = (w_sel_bc == '0) || (w_sel_bc > BURST_WIDTH'(MAX_BURST));

    assign w_rd_acc = mem_read  & ~mem_waitrequest;
    assign w_wr_acc = mem_write & ~mem_waitrequest;

    // Responses are steered by the head tag; a beat with no tag is dropped.
    assign w_rsp_hit  = reset_reset_n & mem_readdatavalid & ~w_fifo_empty;
    assign w_pop      = w_rsp_hit & (w_head.beats <= BURST_WIDTH'(1));
    assign w_dec      = w_rsp_hit & ~w_pop;
    assign w_push_tag = '{id: w_gnt_id, beats: w_bc_eff};

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = w_rsp_hit & ~w_head.id;
    assign m1_readdatavalid = w_rsp_hit &  w_head.id;

    assign rd_outstanding = reset_reset_n ? w_fifo_count : '0;
    assign err_burst      = reset_reset_n & r_err_burst;
    assign err_rsp        = reset_reset_n & r_err_rsp;

    lmarb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk       (host_clk_clk),
        .i_rst_n     (reset_reset_n),
        .i_push      (w_rd_acc),
        .i_push_data (w_push_tag),
        .i_pop       (w_pop),
        .i_dec       (w_dec),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Grant: round-robin tie-break in ARB, locked master during a write burst.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (r_state == WR_BURST) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = r_lock_id;
        end else begin
            w_gnt_vld = w_req0 | w_req1;
            if (w_req0 && w_req1) begin
                w_gnt_id = r_rr_ptr;
            end else begin
                w_gnt_id = w_req1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge host_clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: multi-beat write locks the grant until its last accepted beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB: begin
                if (w_wr_acc && (w_bc_eff > BURST_WIDTH'(1))) begin
                    w_state_nxt = WR_BURST;
                end
            end
            WR_BURST: begin
                if (w_wr_acc && (r_beats_left <= BURST_WIDTH'(1))) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // FSM outputs: forward strobes of the granted master; reads are never forwarded mid write burst.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        if (reset_reset_n && w_gnt_vld) begin
            mem_read  = (r_state == ARB) & w_sel_read & ~w_fifo_full;
            mem_write = w_sel_write;
            if (w_gnt_id) begin
                m1_waitrequest = mem_waitrequest | ~((r_state == ARB) & w_sel_read & ~w_fifo_full) & ~w_sel_write;
            end else begin
                m0_waitrequest = mem_waitrequest | ~((r_state == ARB) & w_sel_read & ~w_fifo_full) & ~w_sel_write;
            end
        end
    end

    // Round-robin pointer, burst lock and remaining-beat tracking.
    always_ff @(posedge host_clk_clk) begin
        if (!reset_reset_n) begin
            r_rr_ptr     <= 1'b0;
            r_lock_id    <= 1'b0;
            r_beats_left <= '0;
        end else if (r_state == ARB) begin
            if (w_rd_acc) begin
                r_rr_ptr <= ~w_gnt_id;
            end else if (w_wr_acc) begin
                if (w_bc_eff == BURST_WIDTH'(1)) begin
                    r_rr_ptr <= ~w_gnt_id;
                end else begin
                    r_beats_left <= w_bc_eff - BURST_WIDTH'(1);
                    r_lock_id    <= w_gnt_id;
                end
            end
        end else if (w_wr_acc) begin
            r_beats_left <= r_beats_left - BURST_WIDTH'(1);
            if (r_beats_left <= BURST_WIDTH'(1)) begin
                r_rr_ptr <= ~r_lock_id;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge host_clk_clk) begin
        if (!reset_reset_n) begin
            r_err_burst <= 1'b0;
            r_err_rsp   <= 1'b0;
        end else begin
            if ((r_state == ARB) && (w_rd_acc || w_wr_acc) && w_bc_bad) begin
                r_err_burst <= 1'b1;
            end
            if (mem_readdatavalid && w_fifo_empty) begin
                r_err_rsp <= 1'b1;
            end
        end
    end

endmodule
